// File: rtl/crypto_sequencer.sv
// Sequences a key, a base address and a stream of 128-bit blocks through a
// block cipher core, writing each result to consecutive SRAM addresses.
module crypto_sequencer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [128:0] data_in,
    input  logic         read,
    input  logic [31:0]  sram_addr,
    input  logic         read_addr,
    input  logic         last_packet,
    output logic [127:0] key,
    output logic [127:0] blk_in,
    output logic         blk_start,
    input  logic         blk_done,
    input  logic [127:0] blk_out,
    output logic         sram_wr_en,
    output logic [31:0]  sram_wr_addr,
    output logic [127:0] sram_wr_data,
    input  logic         sram_wack,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADDR   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    localparam logic [1:0] E_IDLE  = 2'd0;
    localparam logic [1:0] E_START = 2'd1;
    localparam logic [1:0] E_WAIT  = 2'd2;
    localparam logic [1:0] E_WRITE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    eng_state;
    logic [127:0]  fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   wr_addr;

    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic stream_end;
    logic unused_pkt_bit;

    assign unused_pkt_bit = data_in[128];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = (state == STREAM) && read;
    assign pop      = (eng_state == E_WAIT) && blk_done;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    // A push in the final cycle would otherwise be stranded in the FIFO.
    assign stream_end = (state == STREAM) && last_packet && empty &&
                        (eng_state == E_IDLE) && !read;

    assign blk_in       = fifo_mem[rd_ptr];
    assign blk_start    = (eng_state == E_START);
    assign sram_wr_en   = (eng_state == E_WRITE);
    assign sram_wr_addr = wr_addr;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            key   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (read) begin
                        key   <= data_in[127:0];
                        err   <= 1'b0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (read_addr) state <= STREAM;
                end
                STREAM: begin
                    if (push_req && full && !pop) err <= 1'b1;
                    if (stream_end) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_state    <= E_IDLE;
            sram_wr_data <= '0;
        end else begin
            case (eng_state)
                E_IDLE:  if (state == STREAM && !empty) eng_state <= E_START;
                E_START: eng_state <= E_WAIT;
                E_WAIT: begin
                    if (blk_done) begin
                        sram_wr_data <= blk_out;
                        eng_state    <= E_WRITE;
                    end
                end
                E_WRITE: if (sram_wack) eng_state <= E_IDLE;
                default: eng_state <= E_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
        end else if (state == ADDR && read_addr) begin
            wr_addr <= sram_addr;
        end else if (eng_state == E_WRITE && sram_wack) begin
            wr_addr <= wr_addr + 32'(ADDR_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= data_in[127:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
